// File: rtl/mod4_counter.sv
// mod4_counter
//   Free-running wrap-around up/down counter. Every rising clock edge moves
//   the count by exactly one in the direction chosen by `con`, unless a
//   synchronous reset clears it. The output comes straight from the state
//   register, so there is no combinational path from inputs to `cnt`.
//
// Parameters
//   WIDTH : counter width in bits (2 => modulo-4 counting)
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous reset, active-high; clears the count, wins over `con`
//   con : direction control, 0 = count up, 1 = count down
//   cnt : current count value (registered)
module mod4_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             con,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Unsigned WIDTH-bit arithmetic; wrap-around comes from truncation.
  always_comb begin
    cnt_d = cnt_q;
    if (con) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_mod4_counter.sv
// tb_mod4_counter
//   Directed, table-driven bench for mod4_counter (WIDTH = 2). Each table
//   record gives the inputs held across one rising edge and the count
//   expected just after that edge. A hand-written sequence then moves the
//   inputs around between edges to show only edge-time values matter.
module tb_mod4_counter;

  logic       clk;
  logic       rst;
  logic       con;
  logic [1:0] cnt;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  mod4_counter #(.WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .con (con),
    .cnt (cnt)
  );

  // 100-unit period, rising edges at 50, 150, 250, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       con;
    logic [1:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cnt=%b expected=%b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[27];
    vecs = '{
      // reset hold, then con=1 with rst still high
      '{1'b1, 1'b0, 2'd0}, '{1'b1, 1'b0, 2'd0}, '{1'b1, 1'b1, 2'd0},
      // up count with wrap
      '{1'b0, 1'b0, 2'd1}, '{1'b0, 1'b0, 2'd2}, '{1'b0, 1'b0, 2'd3},
      '{1'b0, 1'b0, 2'd0}, '{1'b0, 1'b0, 2'd1},
      // down count with wrap from reset
      '{1'b1, 1'b0, 2'd0},
      '{1'b0, 1'b1, 2'd3}, '{1'b0, 1'b1, 2'd2}, '{1'b0, 1'b1, 2'd1},
      '{1'b0, 1'b1, 2'd0}, '{1'b0, 1'b1, 2'd3},
      // direction change mid-run
      '{1'b1, 1'b0, 2'd0},
      '{1'b0, 1'b0, 2'd1}, '{1'b0, 1'b0, 2'd2},
      '{1'b0, 1'b1, 2'd1}, '{1'b0, 1'b1, 2'd0}, '{1'b0, 1'b1, 2'd3},
      '{1'b0, 1'b0, 2'd0},
      // reset mid-operation at cnt=2, con=1 ignored under reset
      '{1'b0, 1'b0, 2'd1}, '{1'b0, 1'b0, 2'd2},
      '{1'b1, 1'b1, 2'd0}, '{1'b0, 1'b0, 2'd1},
      // reset release with con=1 goes 0 -> 3
      '{1'b1, 1'b0, 2'd0}, '{1'b0, 1'b1, 2'd3}
    };

    rst = 1'b1;
    con = 1'b0;

    for (int i = 0; i < 27; i++) begin
      rst = vecs[i].rst;
      con = vecs[i].con;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), cnt, vecs[i].exp);
    end
    // now at edge+1 with cnt = 3

    // Inputs wiggled between edges; only the values 10 units before the
    // edge should count, and cnt must not move mid-cycle.
    rst = 1'b0;
    con = 1'b0;
    #39;                                  // edge+40
    check("hold_mid_a", cnt, 2'd3);
    con = 1'b1;
    rst = 1'b1;
    #20;                                  // edge+60
    check("hold_mid_b", cnt, 2'd3);
    rst = 1'b0;
    con = 1'b0;
    #30;                                  // edge+90, 10 before next edge
    con = 1'b1;
    @(posedge clk);
    #1;
    check("late_con_down", cnt, 2'd2);    // 3 - 1

    rst = 1'b1;
    #89;                                  // edge+90
    check("hold_before_late_release", cnt, 2'd2);
    rst = 1'b0;
    con = 1'b0;
    @(posedge clk);
    #1;
    check("late_rst_release_up", cnt, 2'd3);  // 2 + 1, reset gone by edge

    #49;                                  // edge+50
    rst = 1'b1;
    con = 1'b1;
    #40;                                  // edge+90
    check("hold_before_late_rst", cnt, 2'd3);
    @(posedge clk);
    #1;
    check("late_rst_clears", cnt, 2'd0);

    rst = 1'b0;
    con = 1'b1;
    #89;
    con = 1'b0;                           // flips back before the edge
    @(posedge clk);
    #1;
    check("late_con_up", cnt, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mod4_counter.md
Name: mod4_counter

Overview:
- Synchronous 2-bit wrap-around up/down counter.
- `con` selects the count direction.
- Free-running: advances on every rising clock edge when not in reset.
- Small utility block for sequencing and indexing; output taken directly from the state register.

Parameters:
WIDTH, 2, counter width in bits; the default of 2 is the configuration in use (modulo-4 counting).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high; clears counter
con  input  1  direction control: 0 = count up, 1 = count down
cnt  output WIDTH  current count value (registered)

Behaviour:
- All state changes occur on the rising edge of `clk` only; no asynchronous paths.
- Reset (already decided): one clock; reset is synchronous and active-high.
  - If `rst` = 1 at a rising edge, `cnt` <= 0.
  - Reset has priority over `con`.
- Reset value of `cnt`: 0.
- Before the first rising edge with `rst` = 1, `cnt` is undefined (X in simulation). No initial value is required.
- Count up: if `rst` = 0 and `con` = 0 at a rising edge, `cnt` <= `cnt` + 1 modulo 2^WIDTH.
  - Wraps 3 -> 0 for WIDTH = 2.
- Count down: if `rst` = 0 and `con` = 1 at a rising edge, `cnt` <= `cnt` - 1 modulo 2^WIDTH.
  - Wraps 0 -> 3 for WIDTH = 2.
- No enable and no hold state: the counter moves by exactly one every non-reset cycle.
- Latency: `cnt` reflects the update one clock edge after the inputs are sampled. `cnt` is purely registered, with no combinational path from inputs to output.
- Direction change mid-count: takes effect on the next rising edge from the current value. No skip, no reload.
- Reset asserted mid-count: the counter clears to 0 on the next rising edge. It holds 0 while `rst` stays high, regardless of `con`.
- Reset deasserted: the first non-reset edge moves `cnt` from 0 to 1 (`con` = 0) or from 0 to 3 (`con` = 1).
- Inputs changing between clock edges have no effect. Only the values present at the rising edge matter.
- Arithmetic is unsigned WIDTH-bit, with natural overflow/underflow truncation. No carry or borrow output.

Test Plan:
1. Reset hold:
   - `rst` = 1, `con` = 0 for 2 edges -> `cnt` = 00 after the first edge and stays 00.
   - Then `con` = 1 with `rst` still 1 -> `cnt` stays 00.
2. Up count with wrap:
   - From reset, `rst` = 0, `con` = 0 for 5 edges -> `cnt` sequence 01, 10, 11, 00, 01.
3. Down count with wrap:
   - From reset, `rst` = 0, `con` = 1 for 5 edges -> `cnt` sequence 11, 10, 01, 00, 11.
4. Direction change mid-run:
   - Up to `cnt` = 10, then `con` = 1 -> next edges give 01, 00, 11.
   - Then `con` = 0 -> next edge gives 00.
5. Reset mid-operation:
   - At `cnt` = 10, assert `rst` = 1 for one edge -> `cnt` = 00 on that edge.
   - Deassert with `con` = 0 -> next edge `cnt` = 01.
6. Input timing:
   - Toggle `con` and `rst` away from the clock edges (e.g. 10 time units before the edge with a 100-unit period).
   - The value present at each rising edge alone determines the next `cnt`.
   - `cnt` never changes between edges.
